dcache_miss_controller: RTL and testbench
=========================================

Name: dcache_miss_controller

Overview:
Sequences the MEM-stage data cache for LW/LB/SW/SB. It stalls the pipeline on a miss, writes back a dirty victim line, and fills the new line from main memory in timed beats. It then lets the access complete as a hit. It sits beside the main control unit, consumes the MEM-stage memory-instruction indication and cache hit/dirty status, and owns the global stall plus all cache/memory enables.

Parameters:
LINE_WORDS, 4, words per cache line (power of two, >=1); one memory beat moves one word
MEM_LATENCY, 4, cycles per memory beat (>=1)
MISS_CNT_W, 32, width of saturating miss counter

Ports:
clk  input  1  clock, rising-edge
rst  input  1  asynchronous active-high reset
mem_access  input  1  MEM stage holds LW/LB/SW/SB
mem_is_store  input  1  access is SW/SB (else load)
hit  input  1  cache tag match for the MEM-stage address
dirty  input  1  victim line dirty (valid when hit=0)
stall  output  1  freeze PC and pipeline registers
mem_read_en  output  1  main-memory read, active during fill beats
mem_write_en  output  1  main-memory write, active during evict beats
beat_idx  output  $clog2(LINE_WORDS) (min 1)  word offset of current beat
cache_fill_we  output  1  one-cycle pulse: write fetched word into cache line at beat_idx
cache_store_we  output  1  store-hit write into cache
load_wb_en  output  1  load data valid for register writeback this cycle
busy  output  1  FSM not in IDLE
miss_count  output  MISS_CNT_W  saturating count of detected misses

Behaviour:
- Reset: async. State IDLE, lat_cnt=0, beat_cnt=0, miss_count=0. All outputs are 0 while rst=1 (IDLE with decoded outputs forced low).
- States: IDLE, EVICT, FILL, COMPLETE.
- IDLE (Mealy outputs; stall=0, busy=0 unless a miss occurs):
  - mem_access & hit: cache_store_we=mem_is_store and load_wb_en=~mem_is_store, same cycle; stay in IDLE.
  - mem_access & ~hit: stall=1 in the same cycle; miss_count += 1 (holds at all-ones); clear counters; next state EVICT if dirty, else FILL.
  - ~mem_access: all outputs 0.
- Inputs are sampled only in IDLE; they are ignored in other states because the pipeline is frozen.
- EVICT: stall=1, busy=1, mem_write_en=1, beat_idx=beat_cnt.
  - lat_cnt counts 0..MEM_LATENCY-1. At MEM_LATENCY-1, lat_cnt wraps to 0 and beat_cnt increments.
  - When beat_cnt=LINE_WORDS-1 and lat_cnt=MEM_LATENCY-1: beat_cnt wraps to 0; next state FILL.
- FILL: stall=1, busy=1, mem_read_en=1, beat_idx=beat_cnt. Counters behave as in EVICT.
  - cache_fill_we=1 only in the last cycle of each beat (lat_cnt=MEM_LATENCY-1).
  - After the last beat: next state COMPLETE.
- COMPLETE: stall=1, busy=1, no memory or cache enables; next state IDLE. The access re-evaluates there as a hit and completes in that cycle.
- Timing:
  - Clean miss: stall high for 1 + LINE_WORDS*MEM_LATENCY + 1 cycles, then the hit cycle.
  - Dirty miss: adds LINE_WORDS*MEM_LATENCY cycles.
- Guards:
  - mem_read_en and mem_write_en are never high together.
  - cache_store_we and load_wb_en are never high outside IDLE.
  - A miss in the IDLE cycle immediately after COMPLETE (e.g. a new instruction) starts a new miss normally.
- Reset mid-operation: outputs drop asynchronously; any partially filled line is abandoned (tag validity is the cache's responsibility).

Decomposition:
- Shared package: state enum (IDLE, EVICT, FILL, COMPLETE) and the memory-opcode localparams (LW, LB, SW, SB) used to derive mem_access/mem_is_store upstream.
- One sub-module, mem_beat_timer:
  - holds lat_cnt and beat_cnt;
  - inputs clear and run;
  - outputs beat_last_cycle, line_done, beat_idx.
  - Instanced once; the FSM drives it in EVICT and FILL.

Test Plan:
1. LINE_WORDS=4, MEM_LATENCY=3; LW with hit=1 -> same cycle load_wb_en=1, stall=0, no memory enables, miss_count stays 0.
2. Clean LW miss (hit=0, dirty=0) -> stall high 14 cycles; mem_read_en 12 cycles; cache_fill_we pulses on FILL cycles 3, 6, 9, 12 with beat_idx 0, 1, 2, 3; then hit=1 gives load_wb_en=1; miss_count=1.
3. Dirty SW miss -> 12 cycles mem_write_en (beat_idx 0..3, 3 cycles each), 12 FILL cycles, COMPLETE; stall high 26 cycles; then cache_store_we=1 for one cycle.
4. Assert rst in the 2nd cycle of FILL beat 2 -> stall, mem_read_en, busy and miss_count go to 0 without a clock edge; after release an idle bus stays quiet.
5. MEM_LATENCY=1, back-to-back misses on consecutive instructions -> each stall is LINE_WORDS+2 cycles; second miss detected in the first IDLE cycle after COMPLETE; miss_count=2.
6. MISS_CNT_W=4, force 17 misses -> miss_count reaches 15 and holds at 15.

Source files
------------

// File: rtl/dcache_miss_controller_pkg.sv
// rtl/dcache_miss_controller_pkg.sv - shared types and constants for the data-cache miss controller
package dcache_miss_controller_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_EVICT    = 2'd1,
      ST_FILL     = 2'd2,
      ST_COMPLETE = 2'd3
   } state_e;

   // Primary opcodes the decode stage uses to raise mem_access / mem_is_store.
   localparam logic [5:0] OP_LB = 6'h20;
   localparam logic [5:0] OP_LW = 6'h23;
   localparam logic [5:0] OP_SB = 6'h28;
   localparam logic [5:0] OP_SW = 6'h2b;

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dcache_miss_controller_mem_beat_timer.sv
// rtl/dcache_miss_controller_mem_beat_timer.sv - latency and beat counters for one cache-line transfer
module mem_beat_timer
   import dcache_miss_controller_pkg::*;
#(
   parameter int LINE_WORDS  = 4,
   parameter int MEM_LATENCY = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               clear,
   input  logic                               run,
   output logic                               beat_last_cycle,
   output logic                               line_done,
   output logic [cnt_width(LINE_WORDS)-1:0]   beat_idx
);

   localparam int LAT_W  = cnt_width(MEM_LATENCY);
   localparam int BEAT_W = cnt_width(LINE_WORDS);
   localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(MEM_LATENCY - 1);
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(LINE_WORDS - 1);

   logic [LAT_W-1:0]  lat_q, lat_d;
   logic [BEAT_W-1:0] beat_q, beat_d;

   assign beat_last_cycle = run && (lat_q == LAT_LAST);
   assign line_done       = beat_last_cycle && (beat_q == BEAT_LAST);
   assign beat_idx        = beat_q;

   // Both counters wrap to zero at the end of a line, so EVICT hands FILL a fresh count.
   always_comb begin
      lat_d  = lat_q;
      beat_d = beat_q;
      if (clear) begin
         lat_d  = '0;
         beat_d = '0;
      end else if (run) begin
         if (lat_q == LAT_LAST) begin
            lat_d  = '0;
            beat_d = (beat_q == BEAT_LAST) ? '0 : beat_q + BEAT_W'(1);
         end else begin
            lat_d = lat_q + LAT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lat_q  <= '0;
         beat_q <= '0;
      end else begin
         lat_q  <= lat_d;
         beat_q <= beat_d;
      end
   end

endmodule

// File: rtl/dcache_miss_controller.sv
// rtl/dcache_miss_controller.sv - MEM-stage data-cache miss sequencer: stall, evict, fill, complete
module dcache_miss_controller
   import dcache_miss_controller_pkg::*;
#(
   parameter int LINE_WORDS  = 4,
   parameter int MEM_LATENCY = 4,
   parameter int MISS_CNT_W  = 32
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             mem_access,
   input  logic                             mem_is_store,
   input  logic                             hit,
   input  logic                             dirty,
   output logic                             stall,
   output logic                             mem_read_en,
   output logic                             mem_write_en,
   output logic [cnt_width(LINE_WORDS)-1:0] beat_idx,
   output logic                             cache_fill_we,
   output logic                             cache_store_we,
   output logic                             load_wb_en,
   output logic                             busy,
   output logic [MISS_CNT_W-1:0]            miss_count
);

   localparam int BEAT_W = cnt_width(LINE_WORDS);

   state_e                state_q, state_d;
   logic [MISS_CNT_W-1:0] miss_q, miss_d;
   logic                  miss;
   logic                  tmr_clear;
   logic                  tmr_run;
   logic                  beat_last_cycle;
   logic                  line_done;
   logic [BEAT_W-1:0]     tmr_beat_idx;

   assign miss      = (state_q == ST_IDLE) && mem_access && !hit;
   assign tmr_clear = (state_q == ST_IDLE);
   assign tmr_run   = (state_q == ST_EVICT) || (state_q == ST_FILL);

   mem_beat_timer #(
      .LINE_WORDS  (LINE_WORDS),
      .MEM_LATENCY (MEM_LATENCY)
   ) u_timer (
      .clk             (clk),
      .rst             (rst),
      .clear           (tmr_clear),
      .run             (tmr_run),
      .beat_last_cycle (beat_last_cycle),
      .line_done       (line_done),
      .beat_idx        (tmr_beat_idx)
   );

   always_comb begin
      state_d = state_q;
      miss_d  = miss_q;
      case (state_q)
         ST_IDLE: begin
            if (miss) begin
               state_d = dirty ? ST_EVICT : ST_FILL;
               if (miss_q != '1) begin
                  miss_d = miss_q + MISS_CNT_W'(1);
               end
            end
         end
         ST_EVICT:    if (line_done) state_d = ST_FILL;
         ST_FILL:     if (line_done) state_d = ST_COMPLETE;
         ST_COMPLETE: state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         miss_q  <= '0;
      end else begin
         state_q <= state_d;
         miss_q  <= miss_d;
      end
   end

   // IDLE outputs follow the inputs in the same cycle so a hit never costs a stall.
   always_comb begin
      stall          = 1'b0;
      mem_read_en    = 1'b0;
      mem_write_en   = 1'b0;
      beat_idx       = '0;
      cache_fill_we  = 1'b0;
      cache_store_we = 1'b0;
      load_wb_en     = 1'b0;
      busy           = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (mem_access) begin
               if (hit) begin
                  cache_store_we = mem_is_store;
                  load_wb_en     = !mem_is_store;
               end else begin
                  stall = 1'b1;
               end
            end
         end
         ST_EVICT: begin
            stall        = 1'b1;
            busy         = 1'b1;
            mem_write_en = 1'b1;
            beat_idx     = tmr_beat_idx;
         end
         ST_FILL: begin
            stall         = 1'b1;
            busy          = 1'b1;
            mem_read_en   = 1'b1;
            beat_idx      = tmr_beat_idx;
            cache_fill_we = beat_last_cycle;
         end
         ST_COMPLETE: begin
            stall = 1'b1;
            busy  = 1'b1;
         end
         default: begin
            stall = 1'b0;
         end
      endcase
      if (rst) begin
         stall          = 1'b0;
         mem_read_en    = 1'b0;
         mem_write_en   = 1'b0;
         beat_idx       = '0;
         cache_fill_we  = 1'b0;
         cache_store_we = 1'b0;
         load_wb_en     = 1'b0;
         busy           = 1'b0;
      end
   end

   assign miss_count = miss_q;

endmodule

// File: tb/tb_dcache_miss_controller.sv
// tb/tb_dcache_miss_controller.sv - directed self-checking bench for dcache_miss_controller
module tb_dcache_miss_controller;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // DUT A: LINE_WORDS=4, MEM_LATENCY=3
   logic        a_rst, a_acc, a_st, a_hit, a_dirty;
   logic        a_stall, a_rd, a_wr, a_fill, a_store, a_load, a_busy;
   logic [1:0]  a_beat;
   logic [31:0] a_cnt;
   logic [8:0]  a_vec;

   // DUT B: LINE_WORDS=4, MEM_LATENCY=1, 4-bit counter
   logic        b_rst, b_acc, b_st, b_hit, b_dirty;
   logic        b_stall, b_rd, b_wr, b_fill, b_store, b_load, b_busy;
   logic [1:0]  b_beat;
   logic [3:0]  b_cnt;
   logic [8:0]  b_vec;

   logic [8:0]  exp_vec;
   logic        e_stall, e_rd, e_wr, e_fill, e_store, e_load, e_busy;
   logic [1:0]  e_beat;

   assign a_vec = {a_stall, a_rd, a_wr, a_beat, a_fill, a_store, a_load, a_busy};
   assign b_vec = {b_stall, b_rd, b_wr, b_beat, b_fill, b_store, b_load, b_busy};

   dcache_miss_controller #(.LINE_WORDS(4), .MEM_LATENCY(3), .MISS_CNT_W(32)) dut_a (
      .clk            (clk),
      .rst            (a_rst),
      .mem_access     (a_acc),
      .mem_is_store   (a_st),
      .hit            (a_hit),
      .dirty          (a_dirty),
      .stall          (a_stall),
      .mem_read_en    (a_rd),
      .mem_write_en   (a_wr),
      .beat_idx       (a_beat),
      .cache_fill_we  (a_fill),
      .cache_store_we (a_store),
      .load_wb_en     (a_load),
      .busy           (a_busy),
      .miss_count     (a_cnt)
   );

   dcache_miss_controller #(.LINE_WORDS(4), .MEM_LATENCY(1), .MISS_CNT_W(4)) dut_b (
      .clk            (clk),
      .rst            (b_rst),
      .mem_access     (b_acc),
      .mem_is_store   (b_st),
      .hit            (b_hit),
      .dirty          (b_dirty),
      .stall          (b_stall),
      .mem_read_en    (b_rd),
      .mem_write_en   (b_wr),
      .beat_idx       (b_beat),
      .cache_fill_we  (b_fill),
      .cache_store_we (b_store),
      .load_wb_en     (b_load),
      .busy           (b_busy),
      .miss_count     (b_cnt)
   );

   task automatic test_reset();
      @(negedge clk);
      #1;
      checks++;
      if (a_vec !== 9'b0) begin
         errors++;
         $display("FAIL reset_a_outputs got %b exp %b", a_vec, 9'b0);
      end
      checks++;
      if (a_cnt !== 32'd0) begin
         errors++;
         $display("FAIL reset_a_count got %0d exp 0", a_cnt);
      end
      checks++;
      if (b_vec !== 9'b0 || b_cnt !== 4'd0) begin
         errors++;
         $display("FAIL reset_b got %b/%0d exp 0/0", b_vec, b_cnt);
      end
      a_acc = 1'b0;
      a_hit = 1'b0;
      a_rst = 1'b0;
      b_rst = 1'b0;
   endtask

   task automatic test_hit();
      @(negedge clk);
      a_acc = 1'b1; a_st = 1'b0; a_hit = 1'b1; a_dirty = 1'b0;
      #1;
      checks++;
      if (a_vec !== 9'b000_00_0_0_1_0) begin
         errors++;
         $display("FAIL load_hit got %b exp %b", a_vec, 9'b000_00_0_0_1_0);
      end
      @(negedge clk);
      a_st = 1'b1;
      #1;
      checks++;
      if (a_vec !== 9'b000_00_0_1_0_0) begin
         errors++;
         $display("FAIL store_hit got %b exp %b", a_vec, 9'b000_00_0_1_0_0);
      end
      @(negedge clk);
      a_acc = 1'b0;
      #1;
      checks++;
      if (a_vec !== 9'b0 || a_cnt !== 32'd0) begin
         errors++;
         $display("FAIL no_access got %b/%0d exp 0/0", a_vec, a_cnt);
      end
   endtask

   task automatic test_clean_miss();
      int n_stall = 0;
      int n_rd = 0;
      for (int k = 0; k <= 14; k++) begin
         @(negedge clk);
         a_acc = 1'b1; a_st = 1'b0; a_dirty = 1'b0; a_hit = (k == 14);
         #1;
         e_stall = (k < 14);
         e_rd    = (k >= 1 && k <= 12);
         e_wr    = 1'b0;
         e_fill  = e_rd && ((k % 3) == 0);
         e_beat  = e_rd ? 2'((k - 1) / 3) : 2'd0;
         e_store = 1'b0;
         e_load  = (k == 14);
         e_busy  = (k >= 1 && k <= 13);
         exp_vec = {e_stall, e_rd, e_wr, e_beat, e_fill, e_store, e_load, e_busy};
         n_stall += int'(a_stall);
         n_rd    += int'(a_rd);
         checks++;
         if (a_vec !== exp_vec) begin
            errors++;
            $display("FAIL clean_miss k=%0d got %b exp %b", k, a_vec, exp_vec);
         end
      end
      checks++;
      if (n_stall != 14 || n_rd != 12) begin
         errors++;
         $display("FAIL clean_miss_lengths stall=%0d rd=%0d exp 14/12", n_stall, n_rd);
      end
      checks++;
      if (a_cnt !== 32'd1) begin
         errors++;
         $display("FAIL clean_miss_count got %0d exp 1", a_cnt);
      end
   endtask

   task automatic test_dirty_miss();
      int n_stall = 0;
      for (int k = 0; k <= 27; k++) begin
         @(negedge clk);
         a_acc = (k < 27); a_st = 1'b1; a_dirty = 1'b1; a_hit = (k >= 26);
         #1;
         e_stall = (k < 26);
         e_wr    = (k >= 1 && k <= 12);
         e_rd    = (k >= 13 && k <= 24);
         e_fill  = e_rd && (((k - 12) % 3) == 0);
         e_beat  = e_wr ? 2'((k - 1) / 3) : (e_rd ? 2'((k - 13) / 3) : 2'd0);
         e_store = (k == 26);
         e_load  = 1'b0;
         e_busy  = (k >= 1 && k <= 25);
         exp_vec = {e_stall, e_rd, e_wr, e_beat, e_fill, e_store, e_load, e_busy};
         n_stall += int'(a_stall);
         checks++;
         if (a_vec !== exp_vec) begin
            errors++;
            $display("FAIL dirty_miss k=%0d got %b exp %b", k, a_vec, exp_vec);
         end
      end
      checks++;
      if (n_stall != 26 || a_cnt !== 32'd2) begin
         errors++;
         $display("FAIL dirty_miss_totals stall=%0d count=%0d exp 26/2", n_stall, a_cnt);
      end
   endtask

   task automatic test_reset_mid_fill();
      for (int k = 0; k <= 8; k++) begin
         @(negedge clk);
         a_acc = 1'b1; a_st = 1'b0; a_dirty = 1'b0; a_hit = 1'b0;
         #1;
         e_stall = 1'b1;
         e_rd    = (k >= 1);
         e_wr    = 1'b0;
         e_fill  = e_rd && ((k % 3) == 0);
         e_beat  = e_rd ? 2'((k - 1) / 3) : 2'd0;
         e_store = 1'b0;
         e_load  = 1'b0;
         e_busy  = (k >= 1);
         exp_vec = {e_stall, e_rd, e_wr, e_beat, e_fill, e_store, e_load, e_busy};
         checks++;
         if (a_vec !== exp_vec) begin
            errors++;
            $display("FAIL pre_reset k=%0d got %b exp %b", k, a_vec, exp_vec);
         end
      end
      checks++;
      if (a_cnt !== 32'd3) begin
         errors++;
         $display("FAIL pre_reset_count got %0d exp 3", a_cnt);
      end
      a_rst = 1'b1;
      #1;
      checks++;
      if (a_vec !== 9'b0 || a_cnt !== 32'd0) begin
         errors++;
         $display("FAIL async_reset got %b/%0d exp 0/0", a_vec, a_cnt);
      end
      a_acc = 1'b0;
      @(negedge clk);
      a_rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         #1;
         checks++;
         if (a_vec !== 9'b0 || a_cnt !== 32'd0) begin
            errors++;
            $display("FAIL post_reset_quiet k=%0d got %b/%0d exp 0/0", k, a_vec, a_cnt);
         end
      end
   endtask

   task automatic test_back_to_back();
      int p;
      for (int k = 0; k <= 12; k++) begin
         @(negedge clk);
         b_acc = 1'b1; b_st = 1'b0; b_dirty = 1'b0; b_hit = (k == 12);
         #1;
         p = k % 6;
         e_stall = (k < 12);
         e_rd    = (k < 12) && (p >= 1 && p <= 4);
         e_wr    = 1'b0;
         e_fill  = e_rd;
         e_beat  = e_rd ? 2'(p - 1) : 2'd0;
         e_store = 1'b0;
         e_load  = (k == 12);
         e_busy  = (k < 12) && (p != 0);
         exp_vec = {e_stall, e_rd, e_wr, e_beat, e_fill, e_store, e_load, e_busy};
         checks++;
         if (b_vec !== exp_vec) begin
            errors++;
            $display("FAIL back_to_back k=%0d got %b exp %b", k, b_vec, exp_vec);
         end
         if (k == 6) begin
            checks++;
            if (b_cnt !== 4'd1) begin
               errors++;
               $display("FAIL b2b_first_count got %0d exp 1", b_cnt);
            end
         end
      end
      checks++;
      if (b_cnt !== 4'd2) begin
         errors++;
         $display("FAIL b2b_count got %0d exp 2", b_cnt);
      end
   endtask

   task automatic test_saturation();
      for (int k = 0; k <= 90; k++) begin
         @(negedge clk);
         b_acc = (k < 90); b_st = 1'b0; b_dirty = 1'b0; b_hit = 1'b0;
         #1;
         if (k == 72) begin
            checks++;
            if (b_cnt !== 4'd14) begin
               errors++;
               $display("FAIL sat_count_14 got %0d exp 14", b_cnt);
            end
         end
         if (k == 73 || k == 84) begin
            checks++;
            if (b_cnt !== 4'd15) begin
               errors++;
               $display("FAIL sat_count_15 k=%0d got %0d exp 15", k, b_cnt);
            end
         end
      end
      checks++;
      if (b_cnt !== 4'd15 || b_vec !== 9'b0) begin
         errors++;
         $display("FAIL sat_hold got %0d/%b exp 15/0", b_cnt, b_vec);
      end
   endtask

   initial begin
      a_rst = 1'b1; a_acc = 1'b1; a_st = 1'b0; a_hit = 1'b1; a_dirty = 1'b0;
      b_rst = 1'b1; b_acc = 1'b1; b_st = 1'b0; b_hit = 1'b1; b_dirty = 1'b0;
      test_reset();
      b_acc = 1'b0;
      b_hit = 1'b0;
      test_hit();
      test_clean_miss();
      test_dirty_miss();
      test_reset_mid_fill();
      test_back_to_back();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
